// File: rtl/traffic_light_fsm_pkg.sv
// Shared types and constants for the traffic light controller:
// state encoding, interval selector codes and one-hot lamp patterns.
package traffic_pkg;

    typedef enum logic [2:0] {MG1, MG2, MY, WALK, SG1, SG2, SY} state_t;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/traffic_light_fsm_if.sv
// Link to the time-parameter block: the FSM drives the interval selector
// and gets the matching duration back combinationally.
interface traffic_light_fsm_if #(parameter int TIMER_W = 4);

    logic [1:0]         interval;
    logic [TIMER_W-1:0] value;

    modport master (output interval, input value);
    modport slave  (input interval, output value);

endinterface

// File: rtl/traffic_light_fsm_timer.sv
// Seconds countdown: loads max(load_value,1) on the cycle after a start
// request, then counts tick pulses and flags the one that ends the interval.
module interval_timer #(
    parameter int TIMER_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               tick,
    input  logic [TIMER_W-1:0] load_value,
    output logic               expired
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] count;
    logic               start_pending;

    // A pending load masks the tick, so a fresh interval never expires early
    assign expired = !start_pending && tick && (count == ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            start_pending <= 1'b1;
        end else begin
            start_pending <= start;
            if (start_pending)
                count <= (load_value == '0) ? ONE : load_value;
            else if (tick && (count > ONE))
                count <= count - ONE;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Top-level light sequencer: walks MG1..SY, asks the time-parameter block
// for each state's duration and advances when the interval timer expires.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int TIMER_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                one_hz_enable,
    input  logic                sensor_sync,
    input  logic                walk_request,
    input  logic                prog_sync,
    traffic_light_fsm_if.master tp,
    output logic [2:0]          main_light,
    output logic [2:0]          side_light,
    output logic                walk_light,
    output logic                walk_reset
);

    state_t state;
    logic   expired;
    logic   advance;

    // Reprogramming overrides a coincident expiry
    assign advance = expired && !prog_sync;

    interval_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (prog_sync || advance),
        .tick       (one_hz_enable),
        .load_value (tp.value),
        .expired    (expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MG1;
            walk_reset <= 1'b0;
        end else if (prog_sync) begin
            state      <= MG1;
            walk_reset <= 1'b0;
        end else begin
            walk_reset <= 1'b0;
            if (expired) begin
                case (state)
                    MG1:  state <= MG2;
                    MG2:  state <= MY;
                    MY:   state <= walk_request ? WALK : SG1;
                    WALK: begin
                        state      <= SG1;
                        walk_reset <= 1'b1;
                    end
                    SG1:  state <= sensor_sync ? SG2 : SY;
                    SG2:  state <= SY;
                    SY:   state <= MG1;
                    default: state <= MG1;
                endcase
            end
        end
    end

    // Interval is decoded from state so the new duration is on value in the
    // same cycle the timer loads it
    always_comb begin
        main_light  = RED;
        side_light  = RED;
        walk_light  = 1'b0;
        tp.interval = INT_BASE;
        case (state)
            MG1:  main_light = GRN;
            MG2: begin
                main_light  = GRN;
                tp.interval = sensor_sync ? INT_EXT : INT_BASE;
            end
            MY: begin
                main_light  = YEL;
                tp.interval = INT_YEL;
            end
            WALK: begin
                walk_light  = 1'b1;
                tp.interval = INT_EXT;
            end
            SG1:  side_light = GRN;
            SG2: begin
                side_light  = GRN;
                tp.interval = INT_EXT;
            end
            SY: begin
                side_light  = YEL;
                tp.interval = INT_YEL;
            end
            default: main_light = GRN;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: stimulus queues the expected state
// sequence, a monitor checks each state's lamps on entry and its tick count.
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic one_hz_enable = 1'b0;
    logic sensor_sync = 1'b0;
    logic walk_request = 1'b0;
    logic prog_sync = 1'b0;
    logic [2:0] main_light, side_light;
    logic walk_light, walk_reset;
    int base_v = 6, ext_v = 3, yel_v = 2;

    traffic_light_fsm_if #(.TIMER_W(4)) tp ();

    traffic_light_fsm #(.TIMER_W(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .one_hz_enable (one_hz_enable),
        .sensor_sync   (sensor_sync),
        .walk_request  (walk_request),
        .prog_sync     (prog_sync),
        .tp            (tp.master),
        .main_light    (main_light),
        .side_light    (side_light),
        .walk_light    (walk_light),
        .walk_reset    (walk_reset)
    );

    always #5 clock = ~clock;

    // Time-parameter block model
    always_comb begin
        tp.value = 4'd0;
        case (tp.interval)
            INT_BASE: tp.value = 4'(base_v);
            INT_EXT:  tp.value = 4'(ext_v);
            INT_YEL:  tp.value = 4'(yel_v);
            default:  tp.value = 4'd0;
        endcase
    end

    // 1 Hz enable: one cycle high out of every four
    initial begin
        forever begin
            repeat (3) @(posedge clock);
            #1 one_hz_enable = 1'b1;
            @(posedge clock);
            #1 one_hz_enable = 1'b0;
        end
    end

    typedef struct {
        state_t     st;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic [1:0] iv;
        logic       wr;
        int         ticks;   // -1: state is cut short, duration not checked
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input state_t st, input logic [2:0] m, input logic [2:0] s,
                        input logic w, input logic [1:0] iv, input logic wr, input int ticks);
        exp_t e;
        e.st = st; e.m = m; e.s = s; e.w = w; e.iv = iv; e.wr = wr; e.ticks = ticks;
        q.push_back(e);
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic wait_out(input logic [2:0] m, input logic [2:0] s, input logic w,
                            input logic [1:0] iv, input string what);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (main_light == m && side_light == s && walk_light == w && tp.interval == iv)
                return;
        end
        checks++;
        errors++;
        $display("FAIL timeout waiting for %s: main=%b side=%b", what, main_light, side_light);
        finish_sim();
    endtask

    // Monitor: a state change is the DUT's output event
    initial begin : monitor
        exp_t   cur;
        bit     have;
        state_t prev;
        bit     prev_rst;
        bit     prev_prog;
        int     ticks;
        have = 0; prev_rst = 0; prev_prog = 0; ticks = 0; prev = MG1;
        forever begin
            @(negedge clock);
            if (walk_reset) wr_count++;
            if (!have || dut.state != prev) begin
                if (have && cur.ticks >= 0)
                    chk($sformatf("%s duration ticks", cur.st.name()), ticks, cur.ticks);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected state: got %s expected none", dut.state.name());
                end else begin
                    cur = q.pop_front();
                    chk($sformatf("%s state", cur.st.name()), int'(dut.state), int'(cur.st));
                    chk($sformatf("%s main_light", cur.st.name()), int'(main_light), int'(cur.m));
                    chk($sformatf("%s side_light", cur.st.name()), int'(side_light), int'(cur.s));
                    chk($sformatf("%s walk_light", cur.st.name()), int'(walk_light), int'(cur.w));
                    chk($sformatf("%s interval", cur.st.name()), int'(tp.interval), int'(cur.iv));
                    chk($sformatf("%s walk_reset", cur.st.name()), int'(walk_reset), int'(cur.wr));
                end
                have  = 1;
                prev  = dut.state;
                ticks = 0;
            end else if (reset_n && prev_rst && !prev_prog && one_hz_enable) begin
                ticks++;
            end
            prev_rst  = reset_n;
            prev_prog = prog_sync;
        end
    end

    initial begin : stim
        // Plain cycle: base 6, yellow 2
        push(MG1, GRN, RED, 0, INT_BASE, 0, 6);
        push(MG2, GRN, RED, 0, INT_BASE, 0, 6);
        push(MY,  YEL, RED, 0, INT_YEL,  0, 2);
        push(SG1, RED, GRN, 0, INT_BASE, 0, 6);
        push(SY,  RED, YEL, 0, INT_YEL,  0, 2);
        #1;
        chk("reset main_light", int'(main_light), int'(3'b001));
        chk("reset side_light", int'(side_light), int'(3'b100));
        chk("reset walk_light", int'(walk_light), 0);
        chk("reset interval", int'(tp.interval), 0);
        chk("reset walk_reset", int'(walk_reset), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Sensor held: extended MG2 and SG2
        wait_out(RED, YEL, 0, INT_YEL, "SY 1");
        push(MG1, GRN, RED, 0, INT_BASE, 0, 6);
        push(MG2, GRN, RED, 0, INT_EXT,  0, 3);
        push(MY,  YEL, RED, 0, INT_YEL,  0, 2);
        push(SG1, RED, GRN, 0, INT_BASE, 0, 6);
        push(SG2, RED, GRN, 0, INT_EXT,  0, 3);
        push(SY,  RED, YEL, 0, INT_YEL,  0, 2);
        wait_out(GRN, RED, 0, INT_BASE, "MG1 2");
        @(posedge clock); #1 sensor_sync = 1'b1;

        // Pedestrian request
        wait_out(RED, YEL, 0, INT_YEL, "SY 2");
        push(MG1,  GRN, RED, 0, INT_BASE, 0, 6);
        push(MG2,  GRN, RED, 0, INT_BASE, 0, 6);
        push(MY,   YEL, RED, 0, INT_YEL,  0, 2);
        push(WALK, RED, RED, 1, INT_EXT,  0, 3);
        push(SG1,  RED, GRN, 0, INT_BASE, 1, 6);
        push(SY,   RED, YEL, 0, INT_YEL,  0, 2);
        wait_out(GRN, RED, 0, INT_BASE, "MG1 3");
        @(posedge clock); #1 sensor_sync = 1'b0; walk_request = 1'b1;
        wait_out(RED, GRN, 0, INT_BASE, "SG1 3");
        @(posedge clock); #1 walk_request = 1'b0;

        // Reprogram in SG1 with new base 9, then zero-length yellow
        wait_out(RED, YEL, 0, INT_YEL, "SY 3");
        push(MG1, GRN, RED, 0, INT_BASE, 0, 6);
        push(MG2, GRN, RED, 0, INT_BASE, 0, 6);
        push(MY,  YEL, RED, 0, INT_YEL,  0, 2);
        push(SG1, RED, GRN, 0, INT_BASE, 0, -1);
        push(MG1, GRN, RED, 0, INT_BASE, 0, 9);
        push(MG2, GRN, RED, 0, INT_BASE, 0, 9);
        push(MY,  YEL, RED, 0, INT_YEL,  0, 1);
        push(SG1, RED, GRN, 0, INT_BASE, 0, 9);
        push(SY,  RED, YEL, 0, INT_YEL,  0, 1);
        wait_out(GRN, RED, 0, INT_BASE, "MG1 4");
        wait_out(RED, GRN, 0, INT_BASE, "SG1 4");
        @(posedge clock); #1 base_v = 9; prog_sync = 1'b1;
        @(posedge clock); #1 prog_sync = 1'b0;
        wait_out(GRN, RED, 0, INT_BASE, "MG1 after prog");
        @(posedge clock); #1 yel_v = 0;

        // Asynchronous reset in WALK
        wait_out(RED, YEL, 0, INT_YEL, "SY 4");
        push(MG1,  GRN, RED, 0, INT_BASE, 0, 9);
        push(MG2,  GRN, RED, 0, INT_BASE, 0, 9);
        push(MY,   YEL, RED, 0, INT_YEL,  0, 1);
        push(WALK, RED, RED, 1, INT_EXT,  0, -1);
        push(MG1,  GRN, RED, 0, INT_BASE, 0, 9);
        push(MG2,  GRN, RED, 0, INT_EXT,  0, -1);
        wait_out(GRN, RED, 0, INT_BASE, "MG1 5");
        @(posedge clock); #1 walk_request = 1'b1;
        wait_out(RED, RED, 1, INT_EXT, "WALK 5");
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset main_light", int'(main_light), int'(3'b001));
        chk("async reset side_light", int'(side_light), int'(3'b100));
        chk("async reset walk_light", int'(walk_light), 0);
        chk("async reset interval", int'(tp.interval), 0);
        chk("async reset walk_reset", int'(walk_reset), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1; sensor_sync = 1'b1;
        wait_out(GRN, RED, 0, INT_EXT, "MG2 after reset");
        repeat (4) @(negedge clock);
        chk("scoreboard left over", q.size(), 0);
        chk("walk_reset pulse count", wr_count, 1);
        finish_sim();
    end

endmodule
